mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/cpu_defs.sv | 23 ++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: bus widths, arbiter state encoding and the memory
// command payload driven onto the single RAM port.
package cpu_defs;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      FWAIT = 3'd2,
      DWAIT = 3'd3,
      STEP  = 3'd4
   } arb_state_e;

   // One cycle's worth of command for the synchronous RAM port
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one synchronous RAM port between the CPU
// (instruction fetch + optional data access per pipeline step) and a host
// loader/debug port. The host is only served while the CPU is idle.
//
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   run, cpu_halted         - start request (IDLE only), HALT seen (STEP only)
//   cpu_i_addr              - fetch address
//   cpu_d_req/we/addr/dataout - data access of the current step
//   cpu_enable              - one-cycle step strobe to the CPU
//   cpu_i_datain/d_datain   - captured instruction / load data
//   host_req/we/addr/wdata  - host access request
//   host_gnt, host_rdata    - combinational grant, captured read data
//   mem_addr/we/wdata/rdata - RAM port (read data one cycle after address)
//   step_count              - number of completed steps (wraps)
module mem_port_arbiter
   import cpu_defs::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              cpu_halted,
   input  logic [ADDR_W-1:0] cpu_i_addr,
   input  logic              cpu_d_req,
   input  logic              cpu_d_we,
   input  logic [ADDR_W-1:0] cpu_d_addr,
   input  logic [DATA_W-1:0] cpu_d_dataout,
   output logic              cpu_enable,
   output logic [DATA_W-1:0] cpu_i_datain,
   output logic [DATA_W-1:0] cpu_d_datain,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] step_count
);

   arb_state_e state;
   arb_state_e state_nxt;
   mem_cmd_t   cmd;
   logic       gnt;
   logic       host_rd_pend;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and RAM port command
   always_comb begin
      state_nxt = state;
      cmd       = '0;
      gnt       = 1'b0;
      case (state)
         IDLE: begin
            // Host wins over run; run is simply re-evaluated next cycle
            if (host_req) begin
               gnt       = 1'b1;
               cmd.addr  = host_addr;
               cmd.we    = host_we;
               cmd.wdata = host_wdata;
            end else if (run) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            cmd.addr  = cpu_i_addr;
            state_nxt = FWAIT;
         end
         FWAIT: begin
            // Instruction returns this cycle; the data access overlaps it
            if (cpu_d_req) begin
               cmd.addr  = cpu_d_addr;
               cmd.we    = cpu_d_we;
               cmd.wdata = cpu_d_dataout;
               state_nxt = cpu_d_we ? STEP : DWAIT;
            end else begin
               state_nxt = STEP;
            end
         end
         DWAIT: state_nxt = STEP;
         STEP:  state_nxt = cpu_halted ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
      // A reset cycle must not let a write or a host grant through
      if (reset) begin
         cmd = '0;
         gnt = 1'b0;
      end
   end

   assign mem_addr   = cmd.addr;
   assign mem_we     = cmd.we;
   assign mem_wdata  = cmd.wdata;
   assign host_gnt   = gnt;
   assign cpu_enable = (state == STEP);

   // Read-data capture and step counter
   always_ff @(posedge clock) begin
      if (reset) begin
         cpu_i_datain <= '0;
         cpu_d_datain <= '0;
         host_rdata   <= '0;
         host_rd_pend <= 1'b0;
         step_count   <= '0;
      end else begin
         host_rd_pend <= gnt & ~host_we;
         if (host_rd_pend) begin
            host_rdata <= mem_rdata;
         end
         if (state == FWAIT) begin
            cpu_i_datain <= mem_rdata;
         end
         if (state == DWAIT) begin
            cpu_d_datain <= mem_rdata;
         end
         if (state == STEP) begin
            step_count <= step_count + DATA_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_mem_port_arbiter;

   typedef enum int {OP_HW, OP_HR, OP_STEP} op_e;

   typedef struct {
      op_e         op;
      logic [7:0]  addr;     // host address or pc
      logic [15:0] data;     // host write data or store data
      logic        d_req;
      logic        d_we;
      logic [7:0]  d_addr;
      int          exp_lat;
      logic [15:0] exp_i;
      logic [15:0] exp_val;  // host read data or cpu_d_datain after step
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        cpu_halted;
   logic [7:0]  cpu_i_addr;
   logic        cpu_d_req;
   logic        cpu_d_we;
   logic [7:0]  cpu_d_addr;
   logic [15:0] cpu_d_dataout;
   logic        cpu_enable;
   logic [15:0] cpu_i_datain;
   logic [15:0] cpu_d_datain;
   logic        host_req;
   logic        host_we;
   logic [7:0]  host_addr;
   logic [15:0] host_wdata;
   logic        host_gnt;
   logic [15:0] host_rdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [15:0] step_count;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model_mem [256];
   logic [15:0] sc_model;
   logic [15:0] d_model;
   logic [15:0] hr_model;
   logic [15:0] ram [256];
   vec_t        tbl [10];

   always #5 clock = ~clock;

   // Synchronous RAM behind the port
   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   mem_port_arbiter dut (
      .clock(clock), .reset(reset), .run(run), .cpu_halted(cpu_halted),
      .cpu_i_addr(cpu_i_addr), .cpu_d_req(cpu_d_req), .cpu_d_we(cpu_d_we),
      .cpu_d_addr(cpu_d_addr), .cpu_d_dataout(cpu_d_dataout),
      .cpu_enable(cpu_enable), .cpu_i_datain(cpu_i_datain),
      .cpu_d_datain(cpu_d_datain), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
      .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .step_count(step_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_enable"}, 32'(cpu_enable), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_gnt"}, 32'(host_gnt), 32'd0);
      chk({tag, "_idata"}, 32'(cpu_i_datain), 32'd0);
      chk({tag, "_ddata"}, 32'(cpu_d_datain), 32'd0);
      chk({tag, "_hrdata"}, 32'(host_rdata), 32'd0);
      chk({tag, "_count"}, 32'(step_count), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      run = 1'b0;
      @(negedge clock); #1;
      reset = 1'b0;
      sc_model = 16'd0;
      d_model  = 16'd0;
      hr_model = 16'd0;
      @(negedge clock); #1;
   endtask

   // Host write; called during an IDLE cycle
   task automatic host_write(input logic [7:0] a, input logic [15:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      #1;
      chk("hw_gnt", 32'(host_gnt), 32'd1);
      chk("hw_we", 32'(mem_we), 32'd1);
      chk("hw_addr", 32'(mem_addr), 32'(a));
      chk("hw_wdata", 32'(mem_wdata), 32'(d));
      chk("hw_enable", 32'(cpu_enable), 32'd0);
      @(negedge clock); #1;
      host_req = 1'b0; host_we = 1'b0;
      model_mem[a] = d;
   endtask

   // Host read: data lands in host_rdata at the edge after the RAM returns it
   task automatic host_read(input logic [7:0] a, input logic [15:0] exp);
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      #1;
      chk("hr_gnt", 32'(host_gnt), 32'd1);
      chk("hr_we", 32'(mem_we), 32'd0);
      chk("hr_addr", 32'(mem_addr), 32'(a));
      @(negedge clock); #1;
      host_req = 1'b0;
      chk("hr_enable", 32'(cpu_enable), 32'd0);
      @(negedge clock); #1;
      chk("hr_data", 32'(host_rdata), 32'(exp));
      hr_model = exp;
   endtask

   // One CPU step starting from IDLE and halting back to IDLE
   task automatic do_step(input logic [7:0] pc, input logic dreq, input logic dwe,
                          input logic [7:0] daddr, input logic [15:0] ddata,
                          input int exp_lat, input logic [15:0] exp_i, input logic [15:0] exp_d);
      int n = 0;
      int we_cnt = 0;
      bit seen = 1'b0;
      cpu_i_addr = pc; cpu_d_req = dreq; cpu_d_we = dwe; cpu_d_addr = daddr;
      cpu_d_dataout = ddata; cpu_halted = 1'b1; run = 1'b1;
      while (!seen && n < 8) begin
         @(negedge clock); #1;
         n++;
         if (n == 1) chk("fetch_addr", 32'(mem_addr), 32'(pc));
         if (host_gnt) chk("step_gnt", 32'(host_gnt), 32'd0);
         if (mem_we) begin
            we_cnt++;
            chk("store_addr", 32'(mem_addr), 32'(daddr));
            chk("store_data", 32'(mem_wdata), 32'(ddata));
            chk("store_cycle", 32'(n), 32'd2);
         end
         if (cpu_enable) seen = 1'b1;
      end
      chk("step_seen", 32'(seen), 32'd1);
      chk("step_latency", 32'(n), 32'(exp_lat));
      chk("store_pulses", 32'(we_cnt), (dreq && dwe) ? 32'd1 : 32'd0);
      chk("instr", 32'(cpu_i_datain), 32'(exp_i));
      chk("ddata", 32'(cpu_d_datain), 32'(exp_d));
      chk("count_in_step", 32'(step_count), 32'(sc_model));
      run = 1'b0;
      @(negedge clock); #1;
      sc_model = sc_model + 16'd1;
      chk("count_after", 32'(step_count), 32'(sc_model));
      chk("enable_low", 32'(cpu_enable), 32'd0);
      chk("hrdata_hold", 32'(host_rdata), 32'(hr_model));
      if (dreq && dwe) model_mem[daddr] = ddata;
      cpu_d_req = 1'b0; cpu_d_we = 1'b0;
      if (!seen) apply_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n;
      int          pulses;
      logic [15:0] e;
      logic [7:0]  pc;
      logic [7:0]  da;
      logic [15:0] dd;
      logic        rq;
      logic        we;
      int          lat;
      logic [15:0] ed;

      //          op       addr   data      dreq  dwe   daddr  lat iexp      val
      tbl[0] = '{OP_HW,   8'h00, 16'h00AB, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h0000};
      tbl[1] = '{OP_HR,   8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h00AB};
      tbl[2] = '{OP_HW,   8'h01, 16'h3C00, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h0000};
      tbl[3] = '{OP_HW,   8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h0000};
      tbl[4] = '{OP_HW,   8'h11, 16'h7A01, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h0000};
      tbl[5] = '{OP_STEP, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 3, 16'h0000, 16'h0000};
      tbl[6] = '{OP_STEP, 8'h11, 16'h0000, 1'b1, 1'b0, 8'h01, 4, 16'h7A01, 16'h3C00};
      tbl[7] = '{OP_STEP, 8'h10, 16'h3CAB, 1'b1, 1'b1, 8'h02, 3, 16'h0000, 16'h3C00};
      tbl[8] = '{OP_HR,   8'h02, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h3CAB};
      tbl[9] = '{OP_HR,   8'h01, 16'h0000, 1'b0, 1'b0, 8'h00, 0, 16'h0000, 16'h3C00};

      reset = 1'b1; run = 1'b0; cpu_halted = 1'b0; cpu_i_addr = '0;
      cpu_d_req = 1'b0; cpu_d_we = 1'b0; cpu_d_addr = '0; cpu_d_dataout = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      sc_model = 16'd0; d_model = 16'd0; hr_model = 16'd0;
      repeat (2) @(negedge clock);
      #1;
      check_reset_vals("por");
      reset = 1'b0;
      @(negedge clock); #1;

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         case (tbl[i].op)
            OP_HW: host_write(tbl[i].addr, tbl[i].data);
            OP_HR: host_read(tbl[i].addr, tbl[i].exp_val);
            default: begin
               do_step(tbl[i].addr, tbl[i].d_req, tbl[i].d_we, tbl[i].d_addr,
                       tbl[i].data, tbl[i].exp_lat, tbl[i].exp_i, tbl[i].exp_val);
               d_model = tbl[i].exp_val;
            end
         endcase
      end

      // Free-running NOP steps: a pulse every 3 cycles, counter 1,2,3
      apply_reset();
      cpu_i_addr = 8'h10; cpu_d_req = 1'b0; cpu_halted = 1'b0; run = 1'b1;
      n = 0; pulses = 0;
      while (pulses < 3 && n < 15) begin
         @(negedge clock); #1;
         n++;
         if (cpu_enable) begin
            pulses++;
            e = 16'(pulses - 1);
            chk("run_period", 32'(n), 32'(3 * pulses));
            chk("run_count", 32'(step_count), 32'(e));
            if (pulses == 3) begin
               cpu_halted = 1'b1; run = 1'b0;
            end
         end
      end
      chk("run_pulses", 32'(pulses), 32'd3);
      @(negedge clock); #1;
      sc_model = 16'd3;
      chk("run_count_final", 32'(step_count), 32'd3);
      chk("run_idle", 32'(cpu_enable), 32'd0);

      // Halt, then host and run together: host first, fetch after host drops
      host_write(8'h05, 16'h1234);
      cpu_i_addr = 8'h10; cpu_d_req = 1'b0; cpu_halted = 1'b1; run = 1'b1;
      n = 0;
      while (!cpu_enable && n < 8) begin
         @(negedge clock); #1;
         n++;
      end
      chk("halt_step_lat", 32'(n), 32'd3);
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock); #1;
         chk("both_gnt", 32'(host_gnt), 32'd1);
         chk("both_enable", 32'(cpu_enable), 32'd0);
         chk("both_addr", 32'(mem_addr), 32'h00);
      end
      sc_model = sc_model + 16'd1;
      chk("both_count", 32'(step_count), 32'(sc_model));
      chk("both_hrdata", 32'(host_rdata), 32'(model_mem[0]));
      hr_model = model_mem[0];
      host_req = 1'b0;
      #1;
      chk("drop_gnt", 32'(host_gnt), 32'd0);
      @(negedge clock); #1;
      chk("fetch_after_drop", 32'(mem_addr), 32'h10);
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 16'hDEAD;
      #1;
      chk("busy_gnt", 32'(host_gnt), 32'd0);
      chk("busy_we", 32'(mem_we), 32'd0);
      chk("busy_addr", 32'(mem_addr), 32'h10);
      @(negedge clock); #1;
      chk("busy_gnt2", 32'(host_gnt), 32'd0);
      chk("busy_we2", 32'(mem_we), 32'd0);
      chk("busy_enable", 32'(cpu_enable), 32'd0);
      @(negedge clock); #1;
      chk("busy_step", 32'(cpu_enable), 32'd1);
      host_req = 1'b0; host_we = 1'b0; run = 1'b0;
      @(negedge clock); #1;
      sc_model = sc_model + 16'd1;
      chk("busy_count", 32'(step_count), 32'(sc_model));
      host_read(8'h05, 16'h1234);

      // Reset in DWAIT of a load step
      cpu_i_addr = 8'h10; cpu_d_req = 1'b1; cpu_d_we = 1'b0; cpu_d_addr = 8'h01;
      cpu_halted = 1'b1; run = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      chk("dwait_enable", 32'(cpu_enable), 32'd0);
      reset = 1'b1; run = 1'b0;
      @(negedge clock); #1;
      check_reset_vals("dwait_rst");
      reset = 1'b0; cpu_d_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock); #1;
         chk("post_rst_enable", 32'(cpu_enable), 32'd0);
      end
      chk("post_rst_count", 32'(step_count), 32'd0);
      sc_model = 16'd0; d_model = 16'd0; hr_model = 16'd0;

      // Reset in FWAIT of a store step: the write must not land
      host_write(8'h20, 16'h1111);
      cpu_i_addr = 8'h10; cpu_d_req = 1'b1; cpu_d_we = 1'b1; cpu_d_addr = 8'h20;
      cpu_d_dataout = 16'h2222; cpu_halted = 1'b1; run = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1; run = 1'b0;
      #1;
      chk("rst_store_we", 32'(mem_we), 32'd0);
      @(negedge clock); #1;
      check_reset_vals("fwait_rst");
      reset = 1'b0; cpu_d_req = 1'b0; cpu_d_we = 1'b0;
      @(negedge clock); #1;
      host_read(8'h20, 16'h1111);

      // Randomized traffic against the transaction model
      for (int a = 0; a < 256; a++) host_write(8'(a), 16'($urandom));
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 3))
            0: host_write(8'($urandom), 16'($urandom));
            1: begin
               da = 8'($urandom);
               host_read(da, model_mem[da]);
            end
            default: begin
               pc = 8'($urandom); da = 8'($urandom); dd = 16'($urandom);
               rq = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
               lat = (rq && !we) ? 4 : 3;
               ed = (rq && !we) ? model_mem[da] : d_model;
               do_step(pc, rq, we, da, dd, lat, model_mem[pc], ed);
               d_model = ed;
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
